// File: rtl/glyph_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : glyph_page_sequencer
// Description : Walks a row of glyph codes, reads each 16x16 glyph from the
//               registered glyph ROM and streams page/column commands plus
//               column data bytes to the OLED byte driver (valid/ready).
//               Optional inverse video per slot: define GLYPH_SEQ_INVERT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_page_sequencer #(
    parameter int NUM_CHARS = 8,
    parameter int START_COL = 0,
    parameter int ROW_PAGE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NUM_CHARS-1:0] text,
`ifdef GLYPH_SEQ_INVERT_EN
    input  logic [NUM_CHARS-1:0]   invert_mask,
`endif
    output logic [3:0]             rom_addr,
    input  logic [127:0]           rom_top,
    input  logic [127:0]           rom_btm,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_dc,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ADDR = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_CMD  = 3'd3;
    localparam logic [2:0] c_DATA = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    localparam logic [2:0] c_LAST_SLOT = 3'(NUM_CHARS - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [2:0]             r_slot;
    logic                   r_half;
    logic [3:0]             r_idx;
    logic [4*NUM_CHARS-1:0] r_text;
    logic [127:0]           r_top;
    logic [127:0]           r_btm;

    logic                   w_fire;
    logic                   w_cmd_last;
    logic                   w_data_last;
    logic                   w_more_slots;
    logic [3:0]             w_next_code;
    logic [2:0]             w_page;
    logic [6:0]             w_col;
    logic [127:0]           w_word;
    logic [7:0]             w_glyph_byte;
    logic [7:0]             w_cmd_byte;
    logic [7:0]             w_data_byte;
    logic                   w_invert;

    assign w_fire       = out_valid & out_ready;
    assign w_cmd_last   = (r_idx == 4'd2);
    assign w_data_last  = (r_idx == 4'd15);
    assign w_more_slots = (r_slot != c_LAST_SLOT);
    assign w_next_code  = 4'(r_text >> {3'(r_slot + 3'd1), 2'b00});

    // Column address wraps naturally in 7 bits.
    assign w_page = 3'(ROW_PAGE) + {2'b00, r_half};
    assign w_col  = 7'(START_COL) + {r_slot, 4'b0000};

    // Byte 0 is the most significant byte of the captured word.
    assign w_word       = r_half ? r_btm : r_top;
    assign w_glyph_byte = w_word[{~r_idx, 3'b000} +: 8];
    assign w_data_byte  = w_glyph_byte ^ {8{w_invert}};

    always_comb begin
        w_cmd_byte = 8'h00;
        case (r_idx)
            4'd0:    w_cmd_byte = {5'b10110, w_page};
            4'd1:    w_cmd_byte = {4'h0, w_col[3:0]};
            default: w_cmd_byte = {5'b00010, w_col[6:4]};
        endcase
    end

`ifdef GLYPH_SEQ_INVERT_EN
    logic [NUM_CHARS-1:0] r_mask;

    assign w_invert = 1'(r_mask >> r_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (r_state == c_IDLE && start) begin
            r_mask <= invert_mask;
        end
    end
`else
    assign w_invert = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (start) w_next_state = c_ADDR;
            c_ADDR: w_next_state = c_WAIT;
            c_WAIT: w_next_state = c_CMD;
            c_CMD:  if (w_fire && w_cmd_last) w_next_state = c_DATA;
            c_DATA: begin
                if (w_fire && w_data_last) begin
                    if (!r_half)          w_next_state = c_CMD;
                    else if (w_more_slots) w_next_state = c_ADDR;
                    else                  w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_dc    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            c_IDLE: busy = 1'b0;
            c_CMD: begin
                out_valid = 1'b1;
                out_data  = w_cmd_byte;
            end
            c_DATA: begin
                out_valid = 1'b1;
                out_dc    = 1'b1;
                out_data  = w_data_byte;
            end
            c_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= 4'h0;
            r_slot   <= 3'd0;
            r_half   <= 1'b0;
            r_idx    <= 4'd0;
            r_text   <= '0;
            r_top    <= '0;
            r_btm    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_text   <= text;
                        rom_addr <= text[3:0];
                        r_slot   <= 3'd0;
                        r_half   <= 1'b0;
                        r_idx    <= 4'd0;
                    end
                end
                c_WAIT: begin
                    r_top  <= rom_top;
                    r_btm  <= rom_btm;
                    r_half <= 1'b0;
                    r_idx  <= 4'd0;
                end
                c_CMD: begin
                    if (w_fire) begin
                        r_idx <= w_cmd_last ? 4'd0 : r_idx + 4'd1;
                    end
                end
                c_DATA: begin
                    if (w_fire) begin
                        if (w_data_last) begin
                            r_idx <= 4'd0;
                            if (!r_half) begin
                                r_half <= 1'b1;
                            end else if (w_more_slots) begin
                                r_slot   <= r_slot + 3'd1;
                                rom_addr <= w_next_code;
                            end
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glyph_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_glyph_page_sequencer
// Description : Directed self-checking bench with a glyph ROM model and a
//               reference byte-stream model for glyph_page_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_page_sequencer;

    localparam int NC = 8;
    localparam int SC = 120;
    localparam int RP = 2;
`ifdef GLYPH_SEQ_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         out_ready = 1'b1;
    logic [31:0]  text = 32'h0;
    logic [7:0]   mask = 8'h0;
    logic [3:0]   rom_addr;
    logic [127:0] rom_top;
    logic [127:0] rom_btm;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_dc;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int gap_cnt = 0;
    bit stall_prev = 1'b0;
    logic [8:0] prev_byte = 9'h0;
    logic [8:0] cap_q[$];
    int         cap_cyc[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glyph_page_sequencer #(
        .NUM_CHARS (NC),
        .START_COL (SC),
        .ROW_PAGE  (RP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .text        (text),
`ifdef GLYPH_SEQ_INVERT_EN
        .invert_mask (mask),
`endif
        .rom_addr    (rom_addr),
        .rom_top     (rom_top),
        .rom_btm     (rom_btm),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_dc      (out_dc),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // Glyph ROM contents: code 1 is a real glyph, code F is empty.
    function automatic logic [7:0] glyph_byte(input logic [3:0] code, input logic half, input int i);
        logic [127:0] w;
        if (code == 4'hF) return 8'h00;
        if (code == 4'h1) begin
            w = half ? 128'h0040_4021_2214_0814_2241_4040_0000_0000
                     : 128'h0000_0000_0020_00FC_2222_2222_FC00_0000;
            return w[127-8*i -: 8];
        end
        return {code, half, 3'(i)} ^ {i[3], 7'b0};
    endfunction

    function automatic logic [127:0] glyph_word(input logic [3:0] code, input logic half);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127-8*i -: 8] = glyph_byte(code, half, i);
        return w;
    endfunction

    always @(posedge clk) begin
        rom_top <= glyph_word(rom_addr, 1'b0);
        rom_btm <= glyph_word(rom_addr, 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] cap_at(input int j);
        return (j < cap_q.size()) ? cap_q[j] : 9'h1FF;
    endfunction

    // One clock: observe outputs mid-cycle, then advance to just after the edge.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_byte", {23'b0, out_dc, out_data}, {23'b0, prev_byte});
            end
            if (out_valid && out_ready) begin
                cap_q.push_back({out_dc, out_data});
                cap_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && !out_valid) gap_cnt++;
            stall_prev = out_valid && !out_ready;
            prev_byte  = {out_dc, out_data};
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] txt, input logic [7:0] msk, input bit rnd, input bit poke);
        int n0;
        int col;
        int page;
        logic [3:0] code;
        logic [7:0] b;
        exp_q.delete();
        cap_q.delete();
        cap_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        gap_cnt  = 0;
        for (int k = 0; k < NC; k++) begin
            code = txt[4*k +: 4];
            col  = (SC + 16 * k) % 128;
            for (int h = 0; h < 2; h++) begin
                page = RP + h;
                exp_q.push_back({1'b0, 8'hB0 | 8'(page)});
                exp_q.push_back({1'b0, 8'(col % 16)});
                exp_q.push_back({1'b0, 8'h10 | 8'(col / 16)});
                for (int i = 0; i < 16; i++) begin
                    b = glyph_byte(code, 1'(h), i);
                    if (INV && msk[k]) b = ~b;
                    exp_q.push_back({1'b1, b});
                end
            end
        end
        text      = txt;
        mask      = msk;
        start     = 1'b1;
        out_ready = 1'b1;
        n0        = cyc;
        step();
        start = 1'b0;
        check("busy_n1", {31'b0, busy}, 32'd1);
        check("addr_n1", {28'b0, rom_addr}, {28'b0, txt[3:0]});
        for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && t == 60) begin
                start = 1'b1;
                text  = ~txt;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("done_cnt", done_cnt, 32'd1);
        check("nbytes", cap_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j < cap_q.size()) check($sformatf("byte%0d", j), {23'b0, cap_q[j]}, {23'b0, exp_q[j]});
        end
        if (!rnd) begin
            check("first_valid_cyc", (cap_cyc.size() > 0) ? cap_cyc[0] : -1, n0 + 3);
            check("last_byte_cyc", (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -1, n0 + 40 * NC);
            check("done_cyc", done_cyc, n0 + 40 * NC + 1);
            check("gap_cycles", gap_cnt, 2 * NC);
        end
        step();
        check("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check("rst_addr",  {28'b0, rom_addr}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data",  {24'b0, out_data}, 32'd0);
        check("rst_dc",    {31'b0, out_dc}, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        rst = 1'b0;
        step();

        // Slot 0 code 1 at col 120, slot 1 code F at wrapped col 8.
        run_frame(32'h0234_56F1, 8'h02, 1'b0, 1'b0);
        check("s0_col_lo", {23'b0, cap_at(1)}, 32'h008);
        check("s0_col_hi", {23'b0, cap_at(2)}, 32'h017);
        check("s0_top5",   {23'b0, cap_at(8)}, 32'h120);
        check("s0_btm1",   {23'b0, cap_at(23)}, 32'h140);
        check("s1_page",   {23'b0, cap_at(38)}, 32'h0B2);
        check("s1_col_lo", {23'b0, cap_at(39)}, 32'h008);
        check("s1_col_hi", {23'b0, cap_at(40)}, 32'h010);
        check("s1_data0",  {23'b0, cap_at(41)}, INV ? 32'h1FF : 32'h100);

        run_frame(32'h0234_56F1, 8'h02, 1'b1, 1'b0);
        run_frame(32'h89AB_CDE1, 8'hA5, 1'b0, 1'b1);

        // Abort a frame mid-DATA with reset.
        text  = 32'h7654_3210;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        check("mid_valid", {31'b0, out_valid}, 32'd1);
        check("mid_dc", {31'b0, out_dc}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        done_cnt = 0;
        repeat (50) step();
        check("abort_nodone", done_cnt, 32'd0);

        run_frame(32'h1111_2222, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
